// File: rtl/lsu_req_ctrl.sv
// LSU request controller: one load/store at a time, alignment check, lane steering and extension.
// Optional WAIT timeout is compiled in when LSU_TIMEOUT_EN is defined.
module lsu_req_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        io_lsu_reqValid,
  output logic [31:0] io_lsu_addr,
  output logic        io_lsu_wen,
  output logic [31:0] io_lsu_wdata,
  output logic [3:0]  io_lsu_wmask,
  output logic [1:0]  io_lsu_size,
  input  logic        io_lsu_respValid,
  input  logic [31:0] io_lsu_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        out_err_q, out_err_d;
  logic [31:0] out_rdata_q, out_rdata_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
`endif

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    unique case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    unique case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Shift the addressed bytes down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] d;
    d = rdata >> {off, 3'b000};
    unique case (size)
      2'b00:   load_align = uns ? {24'd0, d[7:0]} : {{24{d[7]}}, d[7:0]};
      2'b01:   load_align = uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: load_align = d;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_rdata_d = out_rdata_q;
    req_valid_d = 1'b0;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    size_d      = size_q;
    uns_d       = uns_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (misaligned(in_size, in_addr[1:0])) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_rdata_d = 32'd0;
          end else begin
            state_d     = StReq;
            req_valid_d = 1'b1;
            addr_d      = in_addr;
            wen_d       = in_wen;
            wdata_d     = in_wen ? (in_wdata << {in_addr[1:0], 3'b000}) : 32'd0;
            wmask_d     = in_wen ? lane_mask(in_size, in_addr[1:0]) : 4'b0000;
            size_d      = in_size;
            uns_d       = in_unsigned;
          end
        end
      end
      StReq, StWait: begin
        if (io_lsu_respValid) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          out_rdata_d = wen_q ? 32'd0 : load_align(io_lsu_rdata, addr_q[1:0], size_q, uns_q);
        end else if (state_q == StReq) begin
          state_d = StWait;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q + 16'd1 == TimeoutLim) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          out_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          out_rdata_d = 32'd0;
          addr_d      = 32'd0;
          wen_d       = 1'b0;
          wdata_d     = 32'd0;
          wmask_d     = 4'b0000;
          size_d      = 2'b00;
          uns_d       = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_rdata_q <= 32'd0;
      req_valid_q <= 1'b0;
      addr_q      <= 32'd0;
      wen_q       <= 1'b0;
      wdata_q     <= 32'd0;
      wmask_q     <= 4'b0000;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_rdata_q <= out_rdata_d;
      req_valid_q <= req_valid_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_err         = out_err_q;
  assign out_rdata       = out_rdata_q;
  assign io_lsu_reqValid = req_valid_q;
  assign io_lsu_addr     = addr_q;
  assign io_lsu_wen      = wen_q;
  assign io_lsu_wdata    = wdata_q;
  assign io_lsu_wmask    = wmask_q;
  assign io_lsu_size     = size_q;

endmodule

// File: doc/lsu_req_ctrl.md
# lsu_req_ctrl

Initiator side of the core's LSU memory request/response interface (`io_lsu_*`). It takes one load or store at a time from the core's memory stage, checks its alignment, and drives a single-cycle `reqValid` with byte-lane `wmask`/`wdata`. It then waits for `respValid`, aligns and extends read data, and returns a result to the core. It sits between the core datapath and the top-level `io_lsu_*` ports that the memory/UART model answers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before abort. Used only with `LSU_TIMEOUT_EN`. Range 1..65535.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  core request valid.
- `in_ready`  out  1  block can accept a request.
- `in_wen`  in  1  1 = store, 0 = load.
- `in_addr`  in  32  byte address.
- `in_wdata`  in  32  store data, right-aligned.
- `in_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as misaligned).
- `in_unsigned`  in  1  zero-extend the load (lbu/lhu).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  core accepts the result.
- `out_rdata`  out  32  load result, aligned and extended; 0 for stores.
- `out_err`  out  1  misaligned access or timeout.
- `io_lsu_reqValid`  out  1  bus request strobe.
- `io_lsu_addr`  out  32  byte address, unmodified `in_addr`.
- `io_lsu_wen`  out  1  store.
- `io_lsu_wdata`  out  32  lane-shifted store data.
- `io_lsu_wmask`  out  4  byte enables; 0 on loads.
- `io_lsu_size`  out  2  `in_size`.
- `io_lsu_respValid`  in  1  response strobe.
- `io_lsu_rdata`  in  32  word that contains the addressed bytes.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch every `in_*` field.
  - Misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0, size 11): go to DONE with `out_err`=1. No bus request is made.
  - Otherwise go to REQ.
- REQ: `io_lsu_reqValid`=1 for exactly this one cycle. The responder answers every cycle `reqValid` is high, so holding it longer is forbidden. If `respValid` is sampled in REQ, capture it and go to DONE; otherwise go to WAIT.
- WAIT: on `respValid`, capture `rdata` and go to DONE.
- DONE: `out_valid`=1, held stable until `out_ready`, then go to IDLE.
- `respValid` seen in IDLE or DONE is ignored. A second `respValid` for the same request is ignored.
- Lane rules, with `sh` = 8*`addr[1:0]`:
  - `wmask` = byte 0001<<`addr[1:0]`; half 0011<<`addr[1:0]`; word 1111.
  - `wdata` = `in_wdata` << `sh`.
  - Load: `d` = `rdata` >> `sh`. Byte: sign- or zero-extend `d[7:0]`. Half: `d[15:0]`. Word: `d`.
- Bus outputs other than `reqValid` hold the latched request from REQ through DONE. They are 0 in IDLE.

## Timing
- Reset values: `in_ready`=1, and every other output is 0 (`out_valid`, `out_err`, `out_rdata`, all `io_lsu_*`). State is IDLE.
- Reset asserted mid-transaction aborts it immediately. No response is produced, and a later `respValid` is ignored because the FSM is in IDLE.
- Accept at edge 0 → `reqValid` high during cycle 1 → responder `respValid` during cycle 2 → `out_valid` during cycle 3. Minimum load-to-use latency is 3 cycles.
- Misaligned: `out_valid` the cycle after acceptance.
- Back-to-back: the next request is accepted on the cycle after `out_valid`&&`out_ready`. Peak throughput is 1 access per 4 cycles.
- `in_ready` is 0 in REQ, WAIT and DONE.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYCLES` without `respValid`, go to DONE with `out_err`=1 and `out_rdata`=0.
  - A late `respValid` is ignored.
- Not defined: no counter. WAIT is held indefinitely until `respValid`.

## Test plan
- Load word `addr`=0x30000000 with memory 0x00100073, responder latency 1 → `reqValid` is high for exactly 1 cycle; `out_rdata`=0x00100073 at cycle 3; `out_err`=0.
- Store byte `addr`=0x10000000, `wdata`=0x00000041 → `wmask`=0001, `io_lsu_wdata`=0x00000041, `wen`=1; `out_valid` follows `respValid`.
- Store half `addr`=0x30000006, `wdata`=0x0000BEEF → `wmask`=1100, `io_lsu_wdata`=0xBEEF0000.
- Load byte `addr`=0x30000003 with `rdata`=0x80FF7F01: signed → 0xFFFFFF80; lbu → 0x00000080. Load half `addr`=0x30000002 signed → 0xFFFF80FF.
- Load word `addr`=0x30000002 → no `reqValid` ever; `out_valid` and `out_err`=1 the next cycle. Then assert `reset` during WAIT of a valid load → all outputs 0 and the following `respValid` produces no `out_valid`.
- With `LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, withhold the response → `out_err`=1, `out_rdata`=0 after 8 WAIT cycles. Hold `out_ready`=0 for 5 cycles → `out_*` stays stable.
